// File: rtl/id_stage.sv
// id_stage: instruction field decode, immediate generation and 32x32 register file
module id_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data,
    input  logic        WrEn,
    input  logic [31:0] DIn,
    output logic [6:0]  opcode,
    output logic [2:0]  f3,
    output logic [6:0]  f7,
    output logic [31:0] Imm,
    output logic [31:0] r1,
    output logic [31:0] r2
);
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] regs [32];
    logic        is_i, is_s, is_b, is_u, is_j;

    assign opcode = data[6:0];
    assign f3     = data[14:12];
    assign f7     = data[31:25];
    assign rd     = data[11:7];
    assign rs1    = data[19:15];
    assign rs2    = data[24:20];

    assign is_i = opcode inside {7'b0010011, 7'b0000011, 7'b1100111};
    assign is_s = opcode == 7'b0100011;
    assign is_b = opcode == 7'b1100011;
    assign is_u = opcode inside {7'b0110111, 7'b0010111};
    assign is_j = opcode == 7'b1101111;

    // immediate selection by format; unknown formats (incl. R-type) give zero
    always_comb begin
        Imm = is_i ? {{20{data[31]}}, data[31:20]} :
              is_s ? {{20{data[31]}}, data[31:25], data[11:7]} :
              is_b ? {{19{data[31]}}, data[31], data[7], data[30:25], data[11:8], 1'b0} :
              is_u ? {data[31:12], 12'b0} :
              is_j ? {{11{data[31]}}, data[31], data[19:12], data[20], data[30:21], 1'b0} :
                     32'h0;
    end

    // register file: async clear, write-back to rd on rising edge, x0 never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else if (WrEn && rd != 5'd0) begin
            regs[rd] <= DIn;
        end
    end

    assign r1 = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
    assign r2 = (rs2 == 5'd0) ? 32'h0 : regs[rs2];
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vectors with a scoreboard queue checked by a negedge monitor
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic        WrEn;
    logic [31:0] DIn;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] Imm, r1, r2;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam int OPC = 0, F3 = 1, F7 = 2, IMM = 3, R1 = 4, R2 = 5;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .data(data), .WrEn(WrEn), .DIn(DIn),
        .opcode(opcode), .f3(f3), .f7(f7), .Imm(Imm), .r1(r1), .r2(r2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] actual(int sel);
        case (sel)
            OPC:     return {25'b0, opcode};
            F3:      return {29'b0, f3};
            F7:      return {25'b0, f7};
            IMM:     return Imm;
            R1:      return r1;
            default: return r2;
        endcase
    endfunction

    // monitor: outputs are settled by the falling edge; drain every pending expectation
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = sb.pop_front();
            a = actual(e.sel);
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, a, e.val);
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [31:0] val);
        sb.push_back('{name, sel, val});
    endtask

    task automatic step(input logic [31:0] d, input logic we, input logic [31:0] din);
        @(posedge clk);
        #1;
        data = d;
        WrEn = we;
        DIn  = din;
    endtask

    task automatic settle;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        data  = 32'h13590913;
        WrEn  = 1'b0;
        DIn   = 32'h0;
        // decode is reset-independent; reads are zero while in reset
        step(32'h13590913, 1'b0, 32'h0);
        expect_val("rst_opcode", OPC, 32'h13);
        expect_val("rst_f3", F3, 32'h0);
        expect_val("rst_f7", F7, 32'h09);
        expect_val("rst_imm", IMM, 32'h00000135);
        expect_val("rst_r1", R1, 32'h0);
        expect_val("rst_r2", R2, 32'h0);
        settle();
        rst_n = 1'b1;
        // write x18 (rd of 0x13590913); r1 reads rs1=18, still 0 before the edge
        step(32'h13590913, 1'b1, 32'h0182A223);
        expect_val("pre_write_r1", R1, 32'h0);
        settle();
        step(32'h13590913, 1'b0, 32'h0);
        expect_val("post_write_r1", R1, 32'h0182A223);
        expect_val("post_write_r2_x21", R2, 32'h0);
        settle();
        // sw decode: rs1=5, rs2=24 both empty
        step(32'h0182A223, 1'b0, 32'h0);
        expect_val("sw_opcode", OPC, 32'h23);
        expect_val("sw_f3", F3, 32'h2);
        expect_val("sw_imm", IMM, 32'h4);
        expect_val("sw_r1", R1, 32'h0);
        expect_val("sw_r2", R2, 32'h0);
        settle();
        // write x21 via an R-type word with rd=21, then read x18/x21 together
        step(32'h00000AB3, 1'b1, 32'hCAFEF00D);
        settle();
        step(32'h13590913, 1'b0, 32'h0);
        expect_val("pair_r1", R1, 32'h0182A223);
        expect_val("pair_r2", R2, 32'hCAFEF00D);
        settle();
        // WrEn=0 must not disturb x18
        step(32'h13590913, 1'b0, 32'h11111111);
        settle();
        // X on data with WrEn=0 must not corrupt either
        step(32'hxxxxxxxx, 1'b0, 32'h22222222);
        settle();
        step(32'h13590913, 1'b0, 32'h0);
        expect_val("no_wren_r1", R1, 32'h0182A223);
        settle();
        // immediate formats
        step(32'hFFF00093, 1'b0, 32'h0);
        expect_val("imm_i_neg", IMM, 32'hFFFFFFFF);
        settle();
        step(32'hFE000EE3, 1'b0, 32'h0);
        expect_val("imm_b", IMM, 32'hFFFFFFFC);
        settle();
        step(32'h12345037, 1'b0, 32'h0);
        expect_val("imm_lui", IMM, 32'h12345000);
        settle();
        step(32'h00001017, 1'b0, 32'h0);
        expect_val("imm_auipc", IMM, 32'h00001000);
        settle();
        step(32'h00848933, 1'b0, 32'h0);
        expect_val("imm_r", IMM, 32'h0);
        settle();
        step(32'h8000006F, 1'b0, 32'h0);
        expect_val("imm_j", IMM, 32'hFFF00000);
        settle();
        // write to x0 ignored
        step(32'h00000033, 1'b1, 32'hDEADBEEF);
        settle();
        step(32'h00000033, 1'b0, 32'h0);
        expect_val("x0_r1", R1, 32'h0);
        expect_val("x0_r2", R2, 32'h0);
        settle();
        // async reset between edges clears x18 without a clock edge
        step(32'h13590913, 1'b0, 32'h0);
        expect_val("pre_async_r1", R1, 32'h0182A223);
        settle();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_val("async_r1", R1, 32'h0);
        expect_val("async_r2", R2, 32'h0);
        settle();
        // write attempted across an edge while in reset is lost
        WrEn = 1'b1;
        DIn  = 32'h55555555;
        @(posedge clk);
        #1;
        WrEn = 1'b0;
        settle();
        rst_n = 1'b1;
        step(32'h13590913, 1'b0, 32'h0);
        expect_val("blocked_write_r1", R1, 32'h0);
        settle();
        // first qualifying edge after reset release writes
        step(32'h13590913, 1'b1, 32'hA5A5A5A5);
        settle();
        step(32'h13590913, 1'b0, 32'h0);
        expect_val("first_write_r1", R1, 32'hA5A5A5A5);
        settle();
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
